// File: rtl/dlatch_reg_file_if.sv
// Bus bundle for dlatch_reg_file: write port, clear request, two read ports and status.
// The master side drives requests; the slave side is the register file.
interface dlatch_reg_file_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             E;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] D;
  logic             clr;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] Q_a;
  logic [WIDTH-1:0] notQ_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] Q_b;
  logic [WIDTH-1:0] notQ_b;
  logic [DEPTH-1:0] valid;
  logic             busy;
  logic             wr_drop;

  modport master (
    output E, waddr, D, clr, raddr_a, raddr_b,
    input  Q_a, notQ_a, Q_b, notQ_b, valid, busy, wr_drop
  );

  modport slave (
    input  E, waddr, D, clr, raddr_a, raddr_b,
    output Q_a, notQ_a, Q_b, notQ_b, valid, busy, wr_drop
  );
endinterface

// File: rtl/dlatch_reg_file.sv
// Flop-based register file: one clocked write port, two combinational read ports
// with true/complement data, per-entry valid bits and a one-entry-per-cycle clear sweep.
module dlatch_reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dlatch_reg_file_if.slave   bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [AW-1:0]    ptr_r;
  logic [AW-1:0]    ptr_s;
  logic             busy_r;
  logic             wr_drop_r;
  logic             wr_en_s;
  logic             drop_s;
  logic             in_range_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] q_a_s;
  logic [WIDTH-1:0] q_b_s;

  // Non-power-of-two depths leave the top of the address space unbacked
  assign in_range_s = ({1'b0, bus.waddr} < DEPTH_W);

  // Next-state, sweep pointer and write accept/drop decisions
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    wr_en_s = 1'b0;
    drop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.clr) begin
          state_s = ST_CLEAR;
          ptr_s   = '0;
          drop_s  = bus.E;
        end else if (bus.E) begin
          wr_en_s = in_range_s;
          drop_s  = ~in_range_s;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_CLEAR: begin
        drop_s = bus.E;
        if (ptr_r == LAST_PTR) begin
          state_s = ST_IDLE;
          ptr_s   = '0;
        end else begin
          ptr_s   = ptr_r + AW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        ptr_s   = '0;
      end
    endcase
  end

  // FSM state, sweep pointer and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      busy_r    <= 1'b0;
      wr_drop_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      busy_r    <= (state_s == ST_CLEAR);
      wr_drop_r <= drop_s;
    end
  end

  // Storage array and valid bits: the sweep owns the array while clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      valid_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      mem_r[ptr_r]   <= '0;
      valid_r[ptr_r] <= 1'b0;
    end else if (wr_en_s) begin
      mem_r[bus.waddr]   <= bus.D;
      valid_r[bus.waddr] <= 1'b1;
    end
  end

  // Read ports: invalid or unbacked addresses read as zero
  always_comb begin
    q_a_s = '0;
    q_b_s = '0;
    if ({1'b0, bus.raddr_a} < DEPTH_W) begin
      if (valid_r[bus.raddr_a]) begin
        q_a_s = mem_r[bus.raddr_a];
      end else begin
        q_a_s = '0;
      end
    end else begin
      q_a_s = '0;
    end
    if ({1'b0, bus.raddr_b} < DEPTH_W) begin
      if (valid_r[bus.raddr_b]) begin
        q_b_s = mem_r[bus.raddr_b];
      end else begin
        q_b_s = '0;
      end
    end else begin
      q_b_s = '0;
    end
  end

  assign bus.Q_a     = q_a_s;
  assign bus.notQ_a  = ~q_a_s;
  assign bus.Q_b     = q_b_s;
  assign bus.notQ_b  = ~q_b_s;
  assign bus.valid   = valid_r;
  assign bus.busy    = busy_r;
  assign bus.wr_drop = wr_drop_r;
endmodule

// File: tb/tb_dlatch_reg_file.sv
// Randomised and directed bench for dlatch_reg_file: an 8x8 and a 6x4 instance
// checked every cycle against an array-based reference model.
module tb_dlatch_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dlatch_reg_file_if #(.WIDTH(8), .DEPTH(8)) if8 ();
  dlatch_reg_file_if #(.WIDTH(4), .DEPTH(6)) if6 ();

  dlatch_reg_file #(.WIDTH(8), .DEPTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  dlatch_reg_file #(.WIDTH(4), .DEPTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model, index 0 = 8x8 instance, 1 = 6x4 instance
  int depth_k [2] = '{8, 6};
  int mask_k  [2] = '{255, 15};
  int m [2][8];
  bit v [2][8];
  int sweep_left [2];
  int sweep_idx  [2];
  bit exp_drop   [2];

  // stimulus applied to each instance
  bit e_v [2];
  int wa [2];
  int dv [2];
  bit clr_v [2];
  int ra [2];
  int rb [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 8; a++) begin
        m[k][a] = 0;
        v[k][a] = 1'b0;
      end
      sweep_left[k] = 0;
      sweep_idx[k]  = 0;
      exp_drop[k]   = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      exp_drop[k] = 1'b0;
      if (sweep_left[k] > 0) begin
        m[k][sweep_idx[k]] = 0;
        v[k][sweep_idx[k]] = 1'b0;
        sweep_idx[k]++;
        sweep_left[k]--;
        exp_drop[k] = e_v[k];
      end else if (clr_v[k]) begin
        sweep_left[k] = depth_k[k];
        sweep_idx[k]  = 0;
        exp_drop[k]   = e_v[k];
      end else if (e_v[k]) begin
        if (wa[k] < depth_k[k]) begin
          m[k][wa[k]] = dv[k] & mask_k[k];
          v[k][wa[k]] = 1'b1;
        end else begin
          exp_drop[k] = 1'b1;
        end
      end
    end
  endtask

  function automatic int exp_q(input int k, input int a);
    if (a < depth_k[k] && v[k][a]) return m[k][a];
    return 0;
  endfunction

  function automatic int exp_valid(input int k);
    int r = 0;
    for (int a = 0; a < depth_k[k]; a++) if (v[k][a]) r |= (1 << a);
    return r;
  endfunction

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      e_v[k] = 1'b0;
      clr_v[k] = 1'b0;
    end
  endtask

  task automatic apply();
    logic [31:0] t;
    if8.E = e_v[0];  if8.clr = clr_v[0];
    t = wa[0]; if8.waddr = t[2:0];
    t = dv[0]; if8.D = t[7:0];
    t = ra[0]; if8.raddr_a = t[2:0];
    t = rb[0]; if8.raddr_b = t[2:0];
    if6.E = e_v[1];  if6.clr = clr_v[1];
    t = wa[1]; if6.waddr = t[2:0];
    t = dv[1]; if6.D = t[3:0];
    t = ra[1]; if6.raddr_a = t[2:0];
    t = rb[1]; if6.raddr_b = t[2:0];
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] qa, nqa, qb, nqb, vl, bz, wd;
      if (k == 0) begin
        qa = 32'(if8.Q_a); nqa = 32'(if8.notQ_a); qb = 32'(if8.Q_b); nqb = 32'(if8.notQ_b);
        vl = 32'(if8.valid); bz = 32'(if8.busy); wd = 32'(if8.wr_drop);
      end else begin
        qa = 32'(if6.Q_a); nqa = 32'(if6.notQ_a); qb = 32'(if6.Q_b); nqb = 32'(if6.notQ_b);
        vl = 32'(if6.valid); bz = 32'(if6.busy); wd = 32'(if6.wr_drop);
      end
      check($sformatf("%s%0d_Qa", ph, k), qa, 32'(exp_q(k, ra[k])));
      check($sformatf("%s%0d_nQa", ph, k), nqa, 32'(~exp_q(k, ra[k]) & mask_k[k]));
      check($sformatf("%s%0d_Qb", ph, k), qb, 32'(exp_q(k, rb[k])));
      check($sformatf("%s%0d_nQb", ph, k), nqb, 32'(~exp_q(k, rb[k]) & mask_k[k]));
      check($sformatf("%s%0d_valid", ph, k), vl, 32'(exp_valid(k)));
      check($sformatf("%s%0d_busy", ph, k), bz, 32'(sweep_left[k] > 0));
      check($sformatf("%s%0d_wr_drop", ph, k), wd, 32'(exp_drop[k]));
    end
  endtask

  // called one time unit after a rising edge; leaves at the same phase of the next cycle
  task automatic tick();
    apply();
    #1;
    check_all("pre");
    model_step();
    @(posedge clk);
    #1;
    check_all("post");
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) begin
      e_v[0] = 1'b1; wa[0] = i; dv[0] = 8'h11 * (i + 1);
      tick();
    end
    idle();
  endtask

  initial begin
    int busy_cnt;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      e_v[k] = 1'b0; clr_v[k] = 1'b0; wa[k] = 0; dv[k] = 0; ra[k] = 0; rb[k] = 0;
    end
    apply();
    #3;
    check("rst_Qa", 32'(if8.Q_a), 32'h00);
    check("rst_nQa", 32'(if8.notQ_a), 32'hFF);
    check("rst_nQb", 32'(if8.notQ_b), 32'hFF);
    check("rst_valid", 32'(if8.valid), 32'h00);
    check("rst_busy", 32'(if8.busy), 32'h0);
    check("rst_wr_drop", 32'(if8.wr_drop), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // two writes, then read both back
    e_v[0] = 1'b1; wa[0] = 3; dv[0] = 8'hA5; tick();
    wa[0] = 5; dv[0] = 8'h3C; tick();
    idle(); ra[0] = 3; rb[0] = 5; tick();
    check("dir_Qa", 32'(if8.Q_a), 32'hA5);
    check("dir_nQa", 32'(if8.notQ_a), 32'h5A);
    check("dir_Qb", 32'(if8.Q_b), 32'h3C);
    check("dir_nQb", 32'(if8.notQ_b), 32'hC3);
    check("dir_valid", 32'(if8.valid), 32'h28);
    check("dir_wr_drop", 32'(if8.wr_drop), 32'h0);

    // read-during-write, no bypass
    e_v[0] = 1'b1; wa[0] = 0; dv[0] = 8'h77; ra[0] = 0;
    apply();
    #1;
    check("rdw_before", 32'(if8.Q_a), 32'h00);
    check("rdw_before_n", 32'(if8.notQ_a), 32'hFF);
    tick();
    check("rdw_after", 32'(if8.Q_a), 32'h77);

    // full sweep, busy high for exactly DEPTH cycles
    fill8();
    clr_v[0] = 1'b1; tick();
    busy_cnt = int'(if8.busy);
    idle();
    for (int i = 0; i < 9; i++) begin
      ra[0] = i % 8; rb[0] = (i + 1) % 8;
      tick();
      busy_cnt += int'(if8.busy);
    end
    check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
    check("sweep_valid_end", 32'(if8.valid), 32'h00);

    // writes colliding with clr and arriving mid-sweep are dropped
    fill8();
    clr_v[0] = 1'b1; e_v[0] = 1'b1; wa[0] = 2; dv[0] = 8'hFF; tick();
    check("drop_clr", 32'(if8.wr_drop), 32'h1);
    idle();
    for (int i = 0; i < 3; i++) tick();
    e_v[0] = 1'b1; tick();
    check("drop_mid", 32'(if8.wr_drop), 32'h1);
    idle();
    for (int i = 0; i < 6; i++) tick();
    ra[0] = 2; tick();
    check("drop_entry2", 32'(if8.Q_a), 32'h00);

    // async reset at sweep step 4
    fill8();
    clr_v[0] = 1'b1; tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", 32'(if8.busy), 32'h0);
    check("arst_valid", 32'(if8.valid), 32'h00);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) tick();
    e_v[0] = 1'b1; wa[0] = 6; dv[0] = 8'h42; tick();
    idle(); ra[0] = 6; tick();
    check("arst_write6", 32'(if8.Q_a), 32'h42);

    // 6-deep instance: unbacked address
    e_v[1] = 1'b1; wa[1] = 1; dv[1] = 4'h9; tick();
    wa[1] = 7; dv[1] = 4'h5; tick();
    check("d6_drop", 32'(if6.wr_drop), 32'h1);
    check("d6_valid", 32'(if6.valid), 32'h02);
    idle(); ra[1] = 7; tick();
    check("d6_Qa", 32'(if6.Q_a), 32'h0);
    check("d6_nQa", 32'(if6.notQ_a), 32'hF);

    // randomised traffic on both instances
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        clr_v[k] = ($urandom_range(0, 24) == 0);
        e_v[k]   = $urandom_range(0, 1);
        wa[k]    = $urandom_range(0, 7);
        dv[k]    = $urandom_range(0, 255);
        ra[k]    = $urandom_range(0, 7);
        rb[k]    = $urandom_range(0, 7);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dlatch_reg_file.md
Name: dlatch_reg_file

Overview:
- Parametrised register file built as the next generation of the team's enable-gated D storage banks.
- Holds DEPTH words of WIDTH bits, with one clocked write port and two combinational read ports.
- Each read port exposes true and complemented data (Q and notQ), per-entry valid bits, and a multi-cycle sequential clear sweep.
- Used as general-purpose lab storage behind the switch/LED datapaths.

Parameters:
- WIDTH, 8, bits per word; must be at least 1.
- DEPTH, 8, number of words; must be at least 2.
- AW, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- E  input  1  write enable.
- waddr  input  AW  write address.
- D  input  WIDTH  write data.
- clr  input  1  request a clear sweep of all entries.
- raddr_a  input  AW  read address, port A.
- Q_a  output  WIDTH  read data, port A.
- notQ_a  output  WIDTH  bitwise complement of Q_a.
- raddr_b  input  AW  read address, port B.
- Q_b  output  WIDTH  read data, port B.
- notQ_b  output  WIDTH  bitwise complement of Q_b.
- valid  output  DEPTH  bit i = entry i holds written data.
- busy  output  1  clear sweep in progress.
- wr_drop  output  1  one-cycle pulse: the previous-cycle write was rejected.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - All entries are 0 and valid = 0.
  - busy = 0, wr_drop = 0, FSM = IDLE, sweep pointer = 0.
  - Q_a = Q_b = 0 and notQ_a = notQ_b = all ones.
- FSM states: IDLE, CLEAR.
- IDLE:
  - If clr = 1: go to CLEAR and load the pointer with 0. clr has priority, so an E = 1 in the same cycle is dropped.
  - Else, if E = 1 and waddr < DEPTH: mem[waddr] <= D and valid[waddr] <= 1.
  - Else, if E = 1 and waddr >= DEPTH (only possible when DEPTH is not a power of 2): the write is dropped.
- CLEAR:
  - Each cycle: mem[ptr] <= 0, valid[ptr] <= 0, ptr <= ptr + 1.
  - The cycle that clears entry DEPTH-1 returns the FSM to IDLE.
  - The sweep lasts exactly DEPTH cycles.
  - clr during CLEAR is ignored; the sweep is not restarted.
  - E during CLEAR is dropped.
- busy: registered, equal to (state == CLEAR). It is high for exactly DEPTH cycles, starting the edge after clr is sampled.
- wr_drop: registered. It is 1 in the cycle after any dropped write (clr priority, CLEAR state, or out-of-range address), and 0 otherwise.
- Reads are combinational from the current stored state:
  - Q_x = mem[raddr_x] if raddr_x < DEPTH and valid[raddr_x] = 1; otherwise 0.
  - notQ_x = ~Q_x always, including the out-of-range and invalid cases.
- Read during write to the same address: the read shows the old value until after the write edge; there is no bypass.
- Both read ports may address the same entry; each returns identical data.
- Entries already cleared during a sweep read 0 immediately. Entries not yet reached read their old data.
- Reset asserted mid-sweep: immediate return to the reset state. The sweep does not resume after rst_n is released.
- No latches are inferred: all storage is edge-triggered flops.

Test Plan:
- Reset, then write D = 8'hA5 to addr 3 and D = 8'h3C to addr 5, then read A = 3 and B = 5:
  - Q_a = A5, notQ_a = 5A, Q_b = 3C, notQ_b = C3.
  - valid = 8'b0010_1000.
  - wr_drop stays 0.
- Read of an unwritten addr 0 → Q = 00, notQ = FF. In the same cycle, write addr 0 = 8'h77 with raddr_a = 0 → Q_a = 00 before the edge and 77 after it.
- Fill all 8 entries with 8'h11 × (index + 1), then pulse clr for one cycle:
  - busy is high for exactly 8 cycles.
  - Entry k reads 0 from the cycle after sweep step k; entries not yet reached still hold old data.
  - valid = 0 at the end.
- Assert E = 1 (addr 2, 8'hFF) on the same edge as clr, and again mid-sweep:
  - wr_drop = 1 in each following cycle.
  - Entry 2 reads 0 after the sweep.
- Assert rst_n = 0 asynchronously (between clock edges) at sweep step 4 of a sweep started with all entries at 8'h11 × (index + 1):
  - busy = 0 and valid = 0 immediately.
  - After release, no further sweep activity occurs.
  - A new write to addr 6 = 8'h42 succeeds.
- DEPTH = 6, WIDTH = 4 instance: write to addr 7 → wr_drop pulses and valid is unchanged; raddr_a = 7 → Q_a = 0, notQ_a = 4'hF.
